// File: rtl/turbo_deint_if.sv
`default_nettype none
// ============================================================================
// Module      : turbo_deint_if
// Description : Write-side strobes and read-side valid/ready stream of the
//               RX turbo deinterleaver buffer, bundled as one interface.
//               slave = buffer side, master = producer/consumer side.
// Revision    : 1.0  initial release
// ============================================================================
interface turbo_deint_if #(
  parameter int SW = 6,
  parameter int AW = 12
);
  logic [1:0]      pb_size;
  logic [2*SW-1:0] din;
  logic            wen;
  logic [AW-1:0]   pb_offset;
  logic            done;
  logic            in_rdy;
  logic [2*SW-1:0] dout;
  logic            dout_vld;
  logic            dout_rdy;
  logic            dout_last;
  logic            ovf_err;
  logic            len_err;

  modport slave (
    input  pb_size, din, wen, pb_offset, done, dout_rdy,
    output in_rdy, dout, dout_vld, dout_last, ovf_err, len_err
  );

  modport master (
    output pb_size, din, wen, pb_offset, done, dout_rdy,
    input  in_rdy, dout, dout_vld, dout_last, ovf_err, len_err
  );
endinterface
`default_nettype wire

// File: rtl/turbo_deint_buf.sv
`default_nettype none
// ============================================================================
// Module      : turbo_deint_buf
// Description : RX turbo deinterleaver block buffer. Soft-bit pairs are
//               written at permuted offsets during FILL, then drained in
//               linear order on a valid/ready stream during DRAIN.
//               Optional write-count check: define TURBO_DEINT_WCNT_CHK_EN.
// Revision    : 1.0  initial release
// ============================================================================
module turbo_deint_buf #(
  parameter int SW    = 6,
  parameter int DEPTH = 2080,
  parameter int AW    = 12
) (
  input  logic         clk,
  input  logic         rst,
  turbo_deint_if.slave bus
);
  localparam int DW = 2 * SW;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Block length in pairs; the reserved code falls back to the smallest PB.
  function automatic logic [AW:0] len_of(input logic [1:0] code);
    case (code)
      2'd1:    len_of = (AW+1)'(544);
      2'd2:    len_of = (AW+1)'(2080);
      default: len_of = (AW+1)'(64);
    endcase
  endfunction

  logic [DW-1:0] mem [DEPTH];

  logic [1:0]    state_q, state_d;
  logic [1:0]    size_q, size_d;
  logic          ovf_q, ovf_d;
  logic [AW:0]   rd_addr_q, rd_addr_d;
  logic          rd_vld_q, rd_vld_d;
  logic          rd_last_q, rd_last_d;
  logic [DW-1:0] rd_data_q;
  logic [DW-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic          last0_q, last0_d, last1_q, last1_d;
  logic [1:0]    cnt_q, cnt_d;

  logic [AW:0]   len;
  logic          in_range;
  logic          pop;
  logic          last_hs;
  logic [2:0]    occ_after;
  logic          rd_en;
  logic          mem_we;

  // The size code is taken live in IDLE so the first write already sees
  // the length it is about to latch.
  assign len      = len_of((state_q == ST_IDLE) ? bus.pb_size : size_q);
  assign in_range = ({1'b0, bus.pb_offset} < len);
  assign pop      = (cnt_q != 2'd0) && bus.dout_rdy;
  assign last_hs  = pop && last0_q;
  // Occupancy of RAM output register plus skid buffer after this cycle's pop;
  // a new read is only issued when it is guaranteed a slot.
  assign occ_after = 3'(cnt_q) + 3'(rd_vld_q) - 3'(pop);
  assign rd_en     = (state_q == ST_DRAIN) && (rd_addr_q < len) && (occ_after < 3'd2);

`ifdef TURBO_DEINT_WCNT_CHK_EN
  logic [11:0] wr_cnt_q, wr_cnt_d;
  logic        len_err_q, len_err_d;
`endif

  // Write acceptance, sticky overflow and block-level state transitions.
  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    ovf_d   = ovf_q;
    mem_we  = 1'b0;
`ifdef TURBO_DEINT_WCNT_CHK_EN
    wr_cnt_d  = wr_cnt_q;
    len_err_d = len_err_q;
`endif
    if (bus.wen) begin
      if ((state_q != ST_DRAIN) && in_range) mem_we = 1'b1;
      else                                   ovf_d  = 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        if (bus.wen) begin
          size_d = bus.pb_size;
          if (bus.pb_size == 2'd3) ovf_d = 1'b1;
          state_d = bus.done ? ST_DRAIN : ST_FILL;
        end
      end
      ST_FILL: begin
        if (bus.done) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (last_hs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef TURBO_DEINT_WCNT_CHK_EN
    // The opening write in IDLE is part of the block, so it is counted too.
    if (mem_we) wr_cnt_d = wr_cnt_q + 12'd1;
    if ((state_q != ST_DRAIN) && (state_d == ST_DRAIN) && (wr_cnt_d != 12'(len)))
      len_err_d = 1'b1;
    if ((state_q == ST_DRAIN) && (state_d == ST_IDLE)) wr_cnt_d = 12'd0;
`endif
  end

  // Linear read issue and 2-entry skid buffer feeding the output stream.
  always_comb begin
    rd_addr_d = rd_addr_q;
    rd_vld_d  = 1'b0;
    rd_last_d = 1'b0;
    buf0_d    = buf0_q;
    buf1_d    = buf1_q;
    last0_d   = last0_q;
    last1_d   = last1_q;
    cnt_d     = cnt_q;
    if (pop) begin
      buf0_d  = buf1_q;
      last0_d = last1_q;
      cnt_d   = cnt_q - 2'd1;
    end
    if (rd_vld_q) begin
      if (cnt_d == 2'd0) begin
        buf0_d  = rd_data_q;
        last0_d = rd_last_q;
      end else begin
        buf1_d  = rd_data_q;
        last1_d = rd_last_q;
      end
      cnt_d = cnt_d + 2'd1;
    end
    if (rd_en) begin
      rd_vld_d  = 1'b1;
      rd_last_d = (rd_addr_q == len - (AW+1)'(1));
      rd_addr_d = rd_addr_q + (AW+1)'(1);
    end
    if (last_hs) rd_addr_d = '0;
  end

  // Block RAM: one write port, one registered read port, no reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[bus.pb_offset] <= bus.din;
    if (rd_en)  rd_data_q <= mem[rd_addr_q[AW-1:0]];
  end

  // Control and stream registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      size_q    <= 2'd0;
      ovf_q     <= 1'b0;
      rd_addr_q <= '0;
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
      buf0_q    <= '0;
      buf1_q    <= '0;
      last0_q   <= 1'b0;
      last1_q   <= 1'b0;
      cnt_q     <= 2'd0;
    end else begin
      state_q   <= state_d;
      size_q    <= size_d;
      ovf_q     <= ovf_d;
      rd_addr_q <= rd_addr_d;
      rd_vld_q  <= rd_vld_d;
      rd_last_q <= rd_last_d;
      buf0_q    <= buf0_d;
      buf1_q    <= buf1_d;
      last0_q   <= last0_d;
      last1_q   <= last1_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef TURBO_DEINT_WCNT_CHK_EN
  // Write counter and sticky length error.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt_q  <= 12'd0;
      len_err_q <= 1'b0;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      len_err_q <= len_err_d;
    end
  end
  assign bus.len_err = len_err_q;
`else
  assign bus.len_err = 1'b0;
`endif

  // in_rdy follows the state directly, so it reads 1 in IDLE out of reset.
  assign bus.in_rdy    = (state_q != ST_DRAIN);
  assign bus.dout      = buf0_q;
  assign bus.dout_vld  = (cnt_q != 2'd0);
  assign bus.dout_last = (cnt_q != 2'd0) && last0_q;
  assign bus.ovf_err   = ovf_q;

endmodule
`default_nettype wire
